// File: rtl/obstacle_engine.sv
// Obstacle mover and collision detector: slides one obstacle across the play field per frame
// at a level-dependent speed, counts completed passes and pulses hit on player overlap.
module obstacle_engine #(
  parameter int unsigned MAX_X    = 695,
  parameter int unsigned OBJ_W    = 20,
  parameter int unsigned OBJ_Y    = 400,
  parameter int unsigned OBJ_H    = 40,
  parameter int unsigned PLAYER_X = 100,
  parameter int unsigned PLAYER_W = 20,
  parameter int unsigned PLAYER_H = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        shapes [30:0],
  input  logic [9:0]  player_y,
  output logic [10:0] obj_count,
  output logic        hit,
  output logic [7:0]  passes,
  output logic        running
);

  typedef enum logic [1:0] {StWait, StRun, StWrap, StHit} state_e;

  localparam logic [11:0] XHi      = 12'(PLAYER_X + PLAYER_W);
  localparam logic [11:0] XLo      = 12'(PLAYER_X);
  localparam logic [11:0] YHi      = 12'(OBJ_Y + OBJ_H);
  localparam logic [11:0] YLo      = 12'(OBJ_Y);
  localparam logic [11:0] ObjW12   = 12'(OBJ_W);
  localparam logic [11:0] PlayerH  = 12'(PLAYER_H);
  localparam logic [11:0] MaxX12   = 12'(MAX_X);
  localparam logic [10:0] MaxX11   = 11'(MAX_X);

  state_e      state_q;
  logic [10:0] obj_q;
  logic        hit_q;
  logic [7:0]  passes_q;
  logic        running_q;

  logic [11:0] obj_x;
  logic [11:0] obj_r;
  logic [11:0] py_top;
  logic [11:0] py_bot;
  logic [11:0] speed;
  logic [11:0] next_x;
  logic        overlap;
  logic        unused_shapes;

  always_comb begin
    obj_x   = {1'b0, obj_q};
    obj_r   = obj_x + ObjW12;
    py_top  = {2'b00, player_y};
    py_bot  = py_top + PlayerH;
    overlap = (obj_x < XHi) && (obj_r > XLo) && (py_top < YHi) && (py_bot > YLo);
    // Bits above [1] select levels that share the base speed.
    speed   = shapes[1] ? 12'd4 : 12'd2;
    next_x  = obj_x + speed;
  end

  always_comb begin
    unused_shapes = 1'b0;
    for (int i = 2; i < 31; i++) begin
      unused_shapes = unused_shapes ^ shapes[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StWait;
      obj_q     <= '0;
      hit_q     <= 1'b0;
      passes_q  <= '0;
      running_q <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      case (state_q)
        StWait: begin
          obj_q <= '0;
          if (start) begin
            state_q   <= StRun;
            passes_q  <= '0;
            running_q <= 1'b1;
          end
        end
        StRun: begin
          if (overlap) begin
            state_q   <= StHit;
            hit_q     <= 1'b1;
            running_q <= 1'b0;
          end else if (frame_tick) begin
            // Clamp so the end position is always presented exactly once per pass.
            if (next_x >= MaxX12) begin
              obj_q   <= MaxX11;
              state_q <= StWrap;
            end else begin
              obj_q <= next_x[10:0];
            end
          end
        end
        StWrap: begin
          obj_q   <= '0;
          state_q <= StRun;
          if (passes_q != 8'hFF) begin
            passes_q <= passes_q + 8'd1;
          end
        end
        StHit: begin
          obj_q   <= '0;
          state_q <= StWait;
        end
        default: begin
          state_q   <= StWait;
          obj_q     <= '0;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign obj_count = obj_q;
  assign hit       = hit_q;
  assign passes    = passes_q;
  assign running   = running_q;

endmodule

// File: tb/tb_obstacle_engine.sv
// Self-checking bench for obstacle_engine: a cycle model pushes expected outputs to a queue as
// stimulus is driven; they are popped and compared after each clock edge.
module tb_obstacle_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic        shapes [30:0];
  logic [9:0]  player_y = '0;
  logic [10:0] obj_count;
  logic        hit;
  logic [7:0]  passes;
  logic        running;

  typedef struct packed {
    logic [10:0] obj;
    logic        hit;
    logic [7:0]  passes;
    logic        running;
  } exp_t;

  exp_t exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Model state: 0 wait, 1 run, 2 wrap, 3 hit
  int m_state = 0;
  int m_obj = 0;
  int m_passes = 0;

  obstacle_engine dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .start      (start),
    .shapes     (shapes),
    .player_y   (player_y),
    .obj_count  (obj_count),
    .hit        (hit),
    .passes     (passes),
    .running    (running)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_obj    = 0;
    m_passes = 0;
  endtask

  task automatic model_advance(input logic ft, input logic st, output exp_t e);
    int  py;
    int  nxt;
    bit  ov;
    py = int'(player_y);
    ov = (m_obj < 120) && (m_obj + 20 > 100) && (py < 440) && (py + 40 > 400);
    case (m_state)
      0: begin
        m_obj = 0;
        if (st) begin
          m_state  = 1;
          m_passes = 0;
        end
      end
      1: begin
        if (ov) begin
          m_state = 3;
        end else if (ft) begin
          nxt = m_obj + (shapes[1] ? 4 : 2);
          if (nxt >= 695) begin
            m_obj   = 695;
            m_state = 2;
          end else begin
            m_obj = nxt;
          end
        end
      end
      2: begin
        m_obj   = 0;
        m_state = 1;
        if (m_passes < 255) m_passes = m_passes + 1;
      end
      default: begin
        m_obj   = 0;
        m_state = 0;
      end
    endcase
    e.obj     = 11'(m_obj);
    e.hit     = (m_state == 3);
    e.passes  = 8'(m_passes);
    e.running = (m_state == 1) || (m_state == 2);
  endtask

  task automatic step(input logic ft, input logic st);
    exp_t e;
    exp_t g;
    frame_tick = ft;
    start      = st;
    model_advance(ft, st, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    start      = 1'b0;
    g = exp_q.pop_front();
    check_eq("sb_obj_count", 32'(obj_count), 32'(g.obj));
    check_eq("sb_hit", 32'(hit), 32'(g.hit));
    check_eq("sb_passes", 32'(passes), 32'(g.passes));
    check_eq("sb_running", 32'(running), 32'(g.running));
  endtask

  initial begin
    for (int i = 0; i < 31; i++) shapes[i] = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_obj_count", 32'(obj_count), 0);
    check_eq("rst_hit", 32'(hit), 0);
    check_eq("rst_passes", 32'(passes), 0);
    check_eq("rst_running", 32'(running), 0);
    reset = 1'b1;

    // Level 0: speed 2
    shapes[0] = 1'b1;
    player_y  = 10'd0;
    step(1'b0, 1'b1);
    check_eq("start_running", 32'(running), 1);
    repeat (10) step(1'b1, 1'b0);
    check_eq("lvl0_obj", 32'(obj_count), 20);

    // Level 1: speed 4
    shapes[1] = 1'b1;
    step(1'b1, 1'b0);
    check_eq("lvl1_obj_a", 32'(obj_count), 24);
    step(1'b0, 1'b0);
    check_eq("lvl1_no_tick", 32'(obj_count), 24);
    step(1'b1, 1'b0);
    check_eq("lvl1_obj_b", 32'(obj_count), 28);

    // Wrap from 692
    repeat (166) step(1'b1, 1'b0);
    check_eq("pre_wrap_obj", 32'(obj_count), 692);
    step(1'b1, 1'b0);
    check_eq("wrap_obj", 32'(obj_count), 695);
    check_eq("wrap_running", 32'(running), 1);
    check_eq("wrap_passes", 32'(passes), 0);
    step(1'b1, 1'b0);
    check_eq("post_wrap_obj", 32'(obj_count), 0);
    check_eq("post_wrap_passes", 32'(passes), 1);

    // Start during RUN is ignored
    step(1'b0, 1'b1);
    check_eq("ign_start_passes", 32'(passes), 1);
    check_eq("ign_start_running", 32'(running), 1);

    // Async reset mid-run at x=300
    repeat (75) step(1'b1, 1'b0);
    check_eq("pre_rst_obj", 32'(obj_count), 300);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_obj_count", 32'(obj_count), 0);
    check_eq("arst_hit", 32'(hit), 0);
    check_eq("arst_passes", 32'(passes), 0);
    check_eq("arst_running", 32'(running), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) step(1'b1, 1'b0);
    check_eq("idle_after_rst_obj", 32'(obj_count), 0);
    check_eq("idle_after_rst_run", 32'(running), 0);

    // Collision at x=84 with player_y=400
    player_y = 10'd400;
    step(1'b0, 1'b1);
    repeat (21) step(1'b1, 1'b0);
    check_eq("col_pre_obj", 32'(obj_count), 84);
    check_eq("col_pre_hit", 32'(hit), 0);
    step(1'b0, 1'b0);
    check_eq("col_hit", 32'(hit), 1);
    check_eq("col_hit_obj", 32'(obj_count), 84);
    check_eq("col_hit_running", 32'(running), 0);
    step(1'b0, 1'b0);
    check_eq("col_after_hit", 32'(hit), 0);
    check_eq("col_after_obj", 32'(obj_count), 0);

    // Overlap and frame_tick together
    player_y = 10'd0;
    step(1'b0, 1'b1);
    repeat (21) step(1'b1, 1'b0);
    player_y = 10'd400;
    step(1'b1, 1'b0);
    check_eq("simul_hit", 32'(hit), 1);
    check_eq("simul_obj_held", 32'(obj_count), 84);
    step(1'b0, 1'b0);

    // Vertical edge: 360+40 is not > 400; 439 overlaps
    player_y = 10'd360;
    step(1'b0, 1'b1);
    repeat (25) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check_eq("edge_obj", 32'(obj_count), 100);
    check_eq("edge_no_hit", 32'(hit), 0);
    check_eq("edge_running", 32'(running), 1);
    player_y = 10'd439;
    step(1'b1, 1'b0);
    check_eq("edge_439_hit", 32'(hit), 1);
    step(1'b0, 1'b0);

    // Saturation over 257 passes (175 clks per pass at speed 4, tick every clk)
    player_y = 10'd0;
    step(1'b0, 1'b1);
    repeat (257 * 175) step(1'b1, 1'b0);
    check_eq("sat_passes", 32'(passes), 255);
    check_eq("sat_obj", 32'(obj_count), 0);
    player_y = 10'd400;
    repeat (22) step(1'b1, 1'b0);
    check_eq("sat_hit", 32'(hit), 1);
    repeat (3) step(1'b1, 1'b0);
    check_eq("hold_passes", 32'(passes), 255);
    check_eq("hold_running", 32'(running), 0);
    step(1'b0, 1'b1);
    check_eq("restart_passes", 32'(passes), 0);
    check_eq("restart_running", 32'(running), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/obstacle_engine.md
# obstacle_engine

Generates the obstacle position and collision events that drive the level state machine. Each frame it moves one obstacle across the play field at a speed set by the current level. It reports the obstacle's x position as `obj_count` and pulses `hit` when the obstacle overlaps the player. It consumes the one-hot `shapes` level vector and sits between the VGA frame-tick generator and the level logic.

## Interface
Parameters:
- `MAX_X`, 695: end-of-pass x position; `obj_count` equals this value for exactly one clk per pass.
- `OBJ_W`, 20: obstacle width, pixels.
- `OBJ_Y`, 400: obstacle top row.
- `OBJ_H`, 40: obstacle height.
- `PLAYER_X`, 100: player left column (fixed).
- `PLAYER_W`, 20: player width.
- `PLAYER_H`, 40: player height.

Ports:
- `clk` in 1: system clock; one clock domain.
- `reset` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-clk pulse, once per video frame.
- `start` in 1: one-clk pulse; launches a run from WAIT.
- `shapes` in 31 (unpacked bit array [30:0]): one-hot level from level logic.
- `player_y` in 10: player top row, sampled every clk.
- `obj_count` out 11: obstacle left x position.
- `hit` out 1: registered one-clk collision pulse.
- `passes` out 8: completed passes since last run start; saturates at 255.
- `running` out 1: high in RUN and WRAP.

## Operation
- States: WAIT, RUN, WRAP, HIT.
- WAIT:
  - `obj_count`=0, `passes` held.
  - `start` → RUN, clear `passes` to 0.
- RUN:
  - Collision is checked every clk on the registered `obj_count` and current `player_y`.
  - Overlap uses 12-bit unsigned compares: `obj_count` < `PLAYER_X+PLAYER_W` AND `obj_count+OBJ_W` > `PLAYER_X` AND `player_y` < `OBJ_Y+OBJ_H` AND `player_y+PLAYER_H` > `OBJ_Y`.
  - Overlap → HIT. Overlap takes priority over `frame_tick` in the same clk, and `obj_count` does not move that clk.
  - Otherwise, on `frame_tick`: next = `obj_count` + speed, in 12 bits.
    - If next ≥ `MAX_X`: `obj_count` ← `MAX_X`, go to WRAP (clamped, so `MAX_X` is always hit exactly).
    - Else: `obj_count` ← next.
- Speed, decoded from `shapes`:
  - `shapes[1]`=1 → 4.
  - Else `shapes[0]`=1 → 2.
  - Else (all zero or only bits [30:2] set) → 2.
  - Multiple bits set: highest index among [1:0] wins.
- WRAP:
  - Lasts exactly one clk with `obj_count`=`MAX_X`.
  - Next clk: `obj_count` ← 0, `passes` ← `passes`+1 (saturating), return to RUN.
  - No collision check, and `frame_tick` is ignored in WRAP.
- HIT:
  - Lasts exactly one clk with `hit`=1; `obj_count` held.
  - Next clk: → WAIT, `obj_count` ← 0.
  - `passes` holds its final value until the next `start`.
- `start` is ignored outside WAIT.
- `running`=1 in RUN and WRAP only.

## Timing
- Reset (async assert, any state): state=WAIT, `obj_count`=0, `hit`=0, `passes`=0, `running`=0. Release is synchronous to `clk`.
- `start` at edge N → `running`=1 after edge N.
- `frame_tick` at edge N → new `obj_count` visible after edge N, i.e. one clk of latency.
- Overlap present before edge N → `hit`=1 during cycle N+1 only; `obj_count`=0 from cycle N+2.
- `obj_count`==`MAX_X` holds for exactly one clk per pass. This guarantees the level logic advances exactly one level per pass.
- `shapes` changes mid-pass take effect at the next `frame_tick`.
- Reset asserted during HIT or WRAP: outputs go to reset values immediately; no residual `hit` pulse.

## Test plan
- Reset: assert `reset`=0 mid-RUN with `obj_count`=300 → `obj_count`=0, `hit`=0, `passes`=0, `running`=0 immediately; no motion until `start`.
- Level 0 speed: `shapes[0]`=1, `start`, 10 `frame_tick`s, `player_y`=0 (no overlap) → `obj_count`=20.
- Level 1 speed: switch to `shapes[1]`=1 → each `frame_tick` adds 4.
- Wrap: `shapes[1]`=1 from `obj_count`=692, one `frame_tick` → `obj_count`=695 for exactly 1 clk, then 0; `passes` 0→1.
- Saturation: run 256 passes → `passes`=255.
- Collision: `player_y`=400, step until `obj_count`=84 (84+20 > 100) → `hit`=1 for exactly 1 clk, then WAIT with `obj_count`=0.
- Simultaneous overlap and `frame_tick` → `hit` pulses and `obj_count` does not advance.
- No-overlap edge: `player_y`=360 (360+40 = 400, not > 400) while obstacle at x=100 → no `hit`.
- Ignored start: `start` during RUN → no state change and `passes` not cleared.
